pilha_lifo: RTL

PILHA_LIFO -- requirements
Module: pilha_lifo

---
 rtl/pilha_lifo.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pilha_lifo.sv
// Word-wide LIFO stack with registered top/second-of-stack outputs, driven by a
// three-state request/execute/respond handshake from a control unit.
module pilha_lifo #(
    parameter int LARGURA      = 16,
    parameter int PROFUNDIDADE = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            pilha_wren,
    input  logic                            controle_pilha,
    input  logic [LARGURA-1:0]              data_pilha,
    output logic [LARGURA-1:0]              topo,
    output logic [LARGURA-1:0]              segundo,
    output logic [$clog2(PROFUNDIDADE):0]   nivel,
    output logic                            cheia,
    output logic                            vazia,
    output logic                            pronto,
    output logic                            erro,
    output logic [1:0]                      estado
);

    localparam int AW = $clog2(PROFUNDIDADE);
    localparam int NW = AW + 1;

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Handshake: a request is taken only in OCIOSO when pilha_wren is high at
    // a rising edge; it executes on the next edge, pronto is high for the one
    // cycle after that, and strobes seen while busy are dropped.

    logic [1:0]         state_q, state_d;
    logic               op_q, op_d;
    logic [LARGURA-1:0] dado_q, dado_d;
    logic [NW-1:0]      nivel_q, nivel_d;
    logic [LARGURA-1:0] topo_q, topo_d;
    logic [LARGURA-1:0] segundo_q, segundo_d;
    logic               cheia_q, cheia_d;
    logic               vazia_q, vazia_d;
    logic               pronto_q, pronto_d;
    logic               erro_q, erro_d;

    logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [AW-1:0]      seg_idx;

    // After a pop the new second word sits three below the old level.
    assign seg_idx = nivel_q[AW-1:0] - AW'(3);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dado_d    = dado_q;
        nivel_d   = nivel_q;
        topo_d    = topo_q;
        segundo_d = segundo_q;
        pronto_d  = 1'b0;
        erro_d    = erro_q;
        mem_we    = 1'b0;
        mem_addr  = nivel_q[AW-1:0];

        case (state_q)
            OCIOSO: begin
                if (pilha_wren) begin
                    op_d    = controle_pilha;
                    dado_d  = data_pilha;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d  = RESP;
                pronto_d = 1'b1;
                if (op_q) begin
                    if (cheia_q) begin
                        erro_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        nivel_d   = nivel_q + NW'(1);
                        topo_d    = dado_q;
                        segundo_d = topo_q;
                    end
                end else begin
                    if (vazia_q) begin
                        erro_d = 1'b1;
                    end else begin
                        nivel_d   = nivel_q - NW'(1);
                        topo_d    = segundo_q;
                        segundo_d = (nivel_q >= NW'(3)) ? mem_q[seg_idx] : '0;
                    end
                end
            end
            RESP: begin
                state_d = OCIOSO;
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase

        cheia_d = (nivel_d == NW'(PROFUNDIDADE));
        vazia_d = (nivel_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= OCIOSO;
            op_q      <= 1'b0;
            dado_q    <= '0;
            nivel_q   <= '0;
            topo_q    <= '0;
            segundo_q <= '0;
            cheia_q   <= 1'b0;
            vazia_q   <= 1'b1;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dado_q    <= dado_d;
            nivel_q   <= nivel_d;
            topo_q    <= topo_d;
            segundo_q <= segundo_d;
            cheia_q   <= cheia_d;
            vazia_q   <= vazia_d;
            pronto_q  <= pronto_d;
            erro_q    <= erro_d;
        end
    end

    // Storage is not cleared by reset; words above nivel are never observed.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[mem_addr] <= dado_q;
        end
    end

    assign topo    = topo_q;
    assign segundo = segundo_q;
    assign nivel   = nivel_q;
    assign cheia   = cheia_q;
    assign vazia   = vazia_q;
    assign pronto  = pronto_q;
    assign erro    = erro_q;
    assign estado  = state_q;

endmodule
